alu_sequencer: RTL and testbench

Multi-cycle issue/writeback stage that sits directly around the 8-bit ALU. It accepts 16-bit register-to-register instructions over a valid/ready handshake and holds an 8x8-bit register file. It drives the ALU's 3-bit control and A/B operands from registered outputs, then captures the ALU result and zero flag and writes the result back to the destination register. One instruction is in flight at a time.

---
 rtl/alu_sequencer_if.sv | 29 ++
 rtl/alu_sequencer.sv | 115 +++++++++++
 tb/tb_alu_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - instruction handshake, ALU operand/result bus and debug port
// slave is the sequencer's view; master is the side driving instructions and the ALU.
interface alu_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [15:0]       in_instr;
  logic              in_ready;
  logic [2:0]        alu_ctrl;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_out;
  logic              alu_zero;
  logic [DATA_W-1:0] result;
  logic              zero_flag;
  logic              done;
  logic [2:0]        dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport slave (
    input  in_valid, in_instr, alu_out, alu_zero, dbg_addr,
    output in_ready, alu_ctrl, alu_a, alu_b, result, zero_flag, done, dbg_data
  );

  modport master (
    output in_valid, in_instr, alu_out, alu_zero, dbg_addr,
    input  in_ready, alu_ctrl, alu_a, alu_b, result, zero_flag, done, dbg_data
  );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - three-state issue/writeback sequencer around an external 8-bit ALU
// Holds an 8x8 register file (r0 hardwired to zero); one instruction in flight at a time.
module alu_sequencer #(
  parameter int DATA_W = 8
) (
  input  logic         clock,
  input  logic         reset,
  alu_sequencer_if.slave bus
);
  localparam logic [2:0] OP_NOP = 3'd4;
  localparam logic [2:0] OP_LI  = 3'd7;
  localparam logic [2:0] CTRL_ADD = 3'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] regs [8];
  logic [2:0]        wr_rd;
  logic              wr_en;

  logic [2:0]        dec_op;
  logic [2:0]        dec_rd;
  logic [2:0]        dec_rs;
  logic [2:0]        dec_rt;
  logic [DATA_W-1:0] dec_imm;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [2:0]        nxt_ctrl;
  logic [DATA_W-1:0] nxt_a;
  logic [DATA_W-1:0] nxt_b;
  logic              nxt_we;
  logic              unused_low_bits;

  assign dec_op  = bus.in_instr[15:13];
  assign dec_rd  = bus.in_instr[12:10];
  assign dec_rs  = bus.in_instr[9:7];
  assign dec_rt  = bus.in_instr[6:4];
  assign dec_imm = bus.in_instr[7:0];
  assign unused_low_bits = ^bus.in_instr[3:0];

  assign rs_val = (dec_rs == 3'd0) ? '0 : regs[dec_rs];
  assign rt_val = (dec_rt == 3'd0) ? '0 : regs[dec_rt];

  // LI reuses the ALU adder (imm + 0) so every write-back comes from alu_out.
  always_comb begin
    nxt_ctrl = dec_op;
    nxt_a    = rs_val;
    nxt_b    = rt_val;
    nxt_we   = 1'b1;
    if (dec_op == OP_LI) begin
      nxt_ctrl = CTRL_ADD;
      nxt_a    = dec_imm;
      nxt_b    = '0;
    end else if (dec_op == OP_NOP) begin
      nxt_ctrl = OP_NOP;
      nxt_a    = '0;
      nxt_b    = '0;
      nxt_we   = 1'b0;
    end
  end

  assign bus.in_ready = (state == IDLE) && !reset;
  assign bus.dbg_data = (bus.dbg_addr == 3'd0) ? '0 : regs[bus.dbg_addr];

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      wr_rd         <= '0;
      wr_en         <= 1'b0;
      bus.alu_ctrl  <= '0;
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.result    <= '0;
      bus.zero_flag <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.in_valid) begin
            bus.alu_ctrl <= nxt_ctrl;
            bus.alu_a    <= nxt_a;
            bus.alu_b    <= nxt_b;
            wr_rd        <= dec_rd;
            wr_en        <= nxt_we;
            state        <= EXEC;
          end
        end
        EXEC: begin
          // Writes to r0 are dropped but result/zero_flag still track the ALU.
          if (wr_en) begin
            if (wr_rd != 3'd0) regs[wr_rd] <= bus.alu_out;
            bus.result    <= bus.alu_out;
            bus.zero_flag <= bus.alu_zero;
          end
          bus.done <= 1'b1;
          state    <= WB;
        end
        WB: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed-vector bench for alu_sequencer with a behavioural ALU
// Inputs change and outputs are sampled on the falling edge.
module tb_alu_sequencer;
  logic clock;
  logic reset;
  int   n_vec;
  int   n_err;
  logic [2:0] ex_ctrl;
  logic [7:0] ex_a;
  logic [7:0] ex_b;
  logic [7:0] alu_y;

  alu_sequencer_if #(.DATA_W(8)) bus ();

  alu_sequencer #(.DATA_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    alu_y = 8'h00;
    case (bus.alu_ctrl)
      3'd0: alu_y = bus.alu_a & bus.alu_b;
      3'd1: alu_y = bus.alu_a | bus.alu_b;
      3'd2: alu_y = bus.alu_a + bus.alu_b;
      3'd3: alu_y = bus.alu_a - bus.alu_b;
      3'd5: alu_y = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 8'd1 : 8'd0;
      3'd6: alu_y = ~(bus.alu_a | bus.alu_b);
      default: alu_y = 8'h00;
    endcase
    bus.alu_out  = alu_y;
    bus.alu_zero = (alu_y == 8'h00);
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rr(input logic [2:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs, input logic [2:0] rt);
    return {op, rd, rs, rt, 4'b0000};
  endfunction

  function automatic logic [15:0] li(input logic [2:0] rd, input logic [7:0] imm);
    return {3'd7, rd, 2'b00, imm};
  endfunction

  task automatic dbg_check(input string tag, input logic [2:0] addr, input logic [7:0] exp);
    bus.dbg_addr = addr;
    #1;
    check_eq(tag, {8'h00, bus.dbg_data}, {8'h00, exp});
  endtask

  // Starts and ends on a falling edge with the sequencer in IDLE; checks 3-cycle cadence.
  task automatic run_instr(input string tag, input logic [15:0] instr);
    int cyc;
    cyc = 0;
    while (!bus.in_ready && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    check_eq({tag, " ready"}, {15'd0, bus.in_ready}, 16'd1);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    bus.in_instr = 16'($urandom);
    @(negedge clock);
    ex_ctrl = bus.alu_ctrl;
    ex_a    = bus.alu_a;
    ex_b    = bus.alu_b;
    check_eq({tag, " exec done"}, {15'd0, bus.done}, 16'd0);
    check_eq({tag, " exec ready"}, {15'd0, bus.in_ready}, 16'd0);
    @(negedge clock);
    check_eq({tag, " wb done"}, {15'd0, bus.done}, 16'd1);
    check_eq({tag, " wb ready"}, {15'd0, bus.in_ready}, 16'd0);
    @(negedge clock);
    check_eq({tag, " idle done"}, {15'd0, bus.done}, 16'd0);
  endtask

  initial begin
    logic [7:0] exp_rf [8];
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_instr = 16'h0000;
    bus.dbg_addr = 3'd0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("rst in_ready", {15'd0, bus.in_ready}, 16'd0);
    check_eq("rst alu_ctrl", {13'd0, bus.alu_ctrl}, 16'd0);
    check_eq("rst alu_a", {8'd0, bus.alu_a}, 16'd0);
    check_eq("rst alu_b", {8'd0, bus.alu_b}, 16'd0);
    check_eq("rst result", {8'd0, bus.result}, 16'd0);
    check_eq("rst zero", {15'd0, bus.zero_flag}, 16'd0);
    check_eq("rst done", {15'd0, bus.done}, 16'd0);
    reset = 1'b0;
    #1;
    check_eq("post rst ready", {15'd0, bus.in_ready}, 16'd1);

    run_instr("li r1,5", li(3'd1, 8'd5));
    run_instr("li r2,3", li(3'd2, 8'd3));
    run_instr("sub r3", rr(3'd3, 3'd3, 3'd1, 3'd2));
    check_eq("sub ctrl", {13'd0, ex_ctrl}, 16'd3);
    check_eq("sub a", {8'd0, ex_a}, 16'd5);
    check_eq("sub b", {8'd0, ex_b}, 16'd3);
    check_eq("sub result", {8'd0, bus.result}, 16'd2);
    check_eq("sub zero", {15'd0, bus.zero_flag}, 16'd0);
    dbg_check("dbg r3", 3'd3, 8'd2);

    run_instr("sub r4", rr(3'd3, 3'd4, 3'd2, 3'd2));
    check_eq("sub0 result", {8'd0, bus.result}, 16'd0);
    check_eq("sub0 zero", {15'd0, bus.zero_flag}, 16'd1);
    run_instr("slt r5 3<5", rr(3'd5, 3'd5, 3'd2, 3'd1));
    dbg_check("slt true r5", 3'd5, 8'd1);
    check_eq("slt true zero", {15'd0, bus.zero_flag}, 16'd0);
    run_instr("slt r5 5<3", rr(3'd5, 3'd5, 3'd1, 3'd2));
    dbg_check("slt false r5", 3'd5, 8'd0);
    check_eq("slt false zero", {15'd0, bus.zero_flag}, 16'd1);

    run_instr("li r1,200", li(3'd1, 8'd200));
    check_eq("li ctrl", {13'd0, ex_ctrl}, 16'd2);
    check_eq("li a", {8'd0, ex_a}, 16'd200);
    check_eq("li b", {8'd0, ex_b}, 16'd0);
    run_instr("li r2,100", li(3'd2, 8'd100));
    run_instr("add wrap", rr(3'd2, 3'd3, 3'd1, 3'd2));
    dbg_check("add wrap r3", 3'd3, 8'd44);
    run_instr("li r1,f0", li(3'd1, 8'hF0));
    run_instr("li r2,3c", li(3'd2, 8'h3C));
    run_instr("and", rr(3'd0, 3'd3, 3'd1, 3'd2));
    dbg_check("and r3", 3'd3, 8'h30);
    run_instr("or", rr(3'd1, 3'd4, 3'd1, 3'd2));
    dbg_check("or r4", 3'd4, 8'hFC);
    run_instr("nor", rr(3'd6, 3'd5, 3'd1, 3'd2));
    dbg_check("nor r5", 3'd5, 8'h03);
    check_eq("nor result", {8'd0, bus.result}, 16'h0003);

    run_instr("li r0,55", li(3'd0, 8'h55));
    dbg_check("dbg r0", 3'd0, 8'h00);
    check_eq("li r0 result", {8'd0, bus.result}, 16'h0055);
    run_instr("add r1,r0,r0", rr(3'd2, 3'd1, 3'd0, 3'd0));
    dbg_check("r1 from r0", 3'd1, 8'h00);
    check_eq("r0 add zero", {15'd0, bus.zero_flag}, 16'd1);
    run_instr("li r6,77", li(3'd6, 8'h77));
    run_instr("nop", rr(3'd4, 3'd6, 3'd2, 3'd3));
    check_eq("nop ctrl", {13'd0, ex_ctrl}, 16'd4);
    check_eq("nop a", {8'd0, ex_a}, 16'd0);
    check_eq("nop b", {8'd0, ex_b}, 16'd0);
    check_eq("nop result", {8'd0, bus.result}, 16'h0077);
    check_eq("nop zero", {15'd0, bus.zero_flag}, 16'd0);
    exp_rf = '{8'h00, 8'h00, 8'h3C, 8'h30, 8'hFC, 8'h03, 8'h77, 8'h00};
    for (int i = 0; i < 8; i++) dbg_check($sformatf("nop rf r%0d", i), 3'(i), exp_rf[i]);

    bus.in_valid = 1'b1;
    bus.in_instr = li(3'd7, 8'h11);
    @(posedge clock);
    @(negedge clock);
    check_eq("hold exec ready", {15'd0, bus.in_ready}, 16'd0);
    bus.in_instr = li(3'd7, 8'h22);
    @(negedge clock);
    check_eq("hold wb ready", {15'd0, bus.in_ready}, 16'd0);
    check_eq("hold wb done", {15'd0, bus.done}, 16'd1);
    dbg_check("hold r7 first", 3'd7, 8'h11);
    bus.in_instr = li(3'd7, 8'h33);
    @(negedge clock);
    check_eq("hold idle ready", {15'd0, bus.in_ready}, 16'd1);
    bus.in_instr = li(3'd6, 8'h44);
    @(negedge clock);
    bus.in_instr = li(3'd7, 8'h55);
    @(negedge clock);
    bus.in_valid = 1'b0;
    dbg_check("hold r6 second", 3'd6, 8'h44);
    dbg_check("hold r7 kept", 3'd7, 8'h11);
    @(negedge clock);

    bus.in_valid = 1'b1;
    bus.in_instr = li(3'd6, 8'd9);
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_eq("abort done", {15'd0, bus.done}, 16'd0);
    check_eq("abort ready", {15'd0, bus.in_ready}, 16'd0);
    check_eq("abort ctrl", {13'd0, bus.alu_ctrl}, 16'd0);
    check_eq("abort a", {8'd0, bus.alu_a}, 16'd0);
    check_eq("abort result", {8'd0, bus.result}, 16'd0);
    check_eq("abort zero", {15'd0, bus.zero_flag}, 16'd0);
    dbg_check("abort r6", 3'd6, 8'd0);
    reset = 1'b0;
    @(negedge clock);
    check_eq("after abort ready", {15'd0, bus.in_ready}, 16'd1);
    check_eq("after abort done", {15'd0, bus.done}, 16'd0);
    dbg_check("after abort r6", 3'd6, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
